// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
//   state_t          : sequencer states IDLE -> ACCESS -> RESP
//   REQ_CPU/REQ_DBG  : requester indices (owner / pointer encoding)
//   ADDR_W_DEF/DATA_W_DEF : default memory geometry (256 x 8)
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick.
//   valid[1:0] : pending requests
//   ptr        : requester preferred when both are valid
//   grant[1:0] : one-hot (or zero) winner
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] && (!valid[1] || ptr == REQ_CPU);
    assign grant[1] = valid[1] && (!valid[0] || ptr == REQ_DBG);
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of a 256x8 shared memory.
// One transaction in flight: accept (IDLE) -> memory access (ACCESS) ->
// one-cycle response pulse (RESP).
// Ports:
//   mem_clk, mem_rst (async, active-high)
//   req0_*/rsp0_* : CPU controller; req1_*/rsp1_* : loader/debug port
//   mem_addr, mem_in, mem_wr_en, mem_rd_en -> memory; mem_out <- memory
// Build option: MEM_ARB_WRPROT_EN rejects requester-1 writes to
// addresses 0..PROT_TOP (access slot is still consumed, rsp1_err = 1).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] PROT_TOP = 8'h0F
) (
    input  logic              mem_clk,
    input  logic              mem_rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_out
);
    state_t            state, state_nxt;
    logic              ptr;
    logic              owner;
    logic              we_q;
    logic              blk_q;     // write suppressed by protection
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        grant;
    logic              acc0, acc1, accept;
    logic              blk_nxt;

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .ptr   (ptr),
        .grant (grant)
    );

    // Ready is forced low during reset so every output reads 0 there.
    assign req0_ready = (state == IDLE) && grant[0] && !mem_rst;
    assign req1_ready = (state == IDLE) && grant[1] && !mem_rst;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign accept     = acc0 || acc1;

`ifdef MEM_ARB_WRPROT_EN
    assign blk_nxt  = acc1 && req1_we && (req1_addr <= PROT_TOP);
    assign rsp0_err = 1'b0;
    assign rsp1_err = rsp1_valid && blk_q;
`else
    logic prot_unused;
    assign prot_unused = &{1'b0, PROT_TOP};
    assign blk_nxt  = 1'b0;
    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
`endif

    // Enables are decoded from state so an async reset drops them at once.
    assign mem_wr_en = (state == ACCESS) && we_q && !blk_q;
    assign mem_rd_en = (state == ACCESS) && !we_q;

    assign rsp0_valid = (state == RESP) && (owner == REQ_CPU);
    assign rsp1_valid = (state == RESP) && (owner == REQ_DBG);
    assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : '0;

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            ptr      <= REQ_CPU;
            owner    <= REQ_CPU;
            we_q     <= 1'b0;
            blk_q    <= 1'b0;
            mem_addr <= '0;
            mem_in   <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                // Winner loses priority to the other side next time.
                ptr      <= acc0 ? REQ_DBG : REQ_CPU;
                owner    <= acc1;
                we_q     <= acc1 ? req1_we    : req0_we;
                mem_addr <= acc1 ? req1_addr  : req0_addr;
                mem_in   <= acc1 ? req1_wdata : req0_wdata;
                blk_q    <= blk_nxt;
            end
            if (state == ACCESS)
                rdata_q <= we_q ? '0 : mem_out;
        end
    end
endmodule
